alu_j: RTL and testbench
========================

Name: alu_j

Overview:
- 8-bit integer ALU for the Jac1-8 CPU datapath.
- Result and status are combinational from opcode, operands and param, and are valid within the same cycle.
- One clocked register, flags_q, holds the status of the last non-NOP operation for conditional-branch logic.
- The sequencer drives opcode/operands each cycle and samples result combinationally.

Parameters:
- DataWidth, 8: operand/result width.
- NumOpCodeBits, 5: opcode width.
- ParamBits, 8: immediate/shift-amount width.
- NumStatusBits, 3: status width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  5  operation select.
- operand1  in  8  first operand (A).
- operand2  in  8  second operand (B).
- param  in  8  immediate value / shift count.
- result  out  8  combinational result.
- status  out  3  combinational flags: [0] carry/overflow, [1] borrow/underflow, [2] zero.
- flags_q  out  3  registered flags of the last non-NOP operation.

Behaviour:
- Opcodes:
  - NOP=00000, ADD=00001, SUB=00010, AND=00011, OR=00100, NOT=00101, XOR=00110, SHL=00111, SHR=01000, VAL=01001.
  - All other opcodes behave as NOP.
- ADD: result=(A+B) mod 256; status[0]=9th sum bit.
- SUB: result=(A-B) mod 256; status[1]=1 when A<B (unsigned).
- AND/OR/XOR: bitwise A op B.
- NOT: result=~B. Operand A is ignored.
- SHL: result=A<<param. SHR: result=A>>param (logical, zero fill).
  - The full 8-bit param is the shift count; a count >=8 gives 0.
  - Shifted-out bits never set status[0] or status[1].
- VAL: result=param, pass-through of the immediate.
- NOP/undefined: result=0, status=0.
- Zero flag: status[2]=1 when result==0 and status[0]==0. Example: 255+1 → result 0, status=001.
- Carry and borrow are 0 for every opcode other than ADD/SUB.
- Status and result are purely combinational. There is no latency, no handshake and no state machine.
- flags_q:
  - On rst_n low, flags_q=000 asynchronously.
  - On each rising clk with rst_n high, flags_q<=status if opcode is not NOP/undefined; otherwise it holds.
  - Reset asserted mid-operation clears flags_q immediately. result/status are unaffected by reset.

Optional Feature:
- Macro ALU_J_ROTATE_EN.
- When defined, two rotate opcodes are added:
  - ROL=01010: result=A rotated left by param[2:0].
  - ROR=01011: result=A rotated right by param[2:0].
  - Carry=0, borrow=0, zero per the rule above. Both update flags_q.
- When undefined, 01010/01011 behave as NOP.

Decomposition:
- Package alu_j_pkg holds:
  - Width constants.
  - Opcode localparams.
  - Status bit index constants: STAT_CARRY=0, STAT_BORROW=1, STAT_ZERO=2.
- Natural sub-module: alu_j_shifter (combinational SHL/SHR and optional rotates).
- The top holds the opcode decode, adder/subtractor, logic unit, flag generation and the flags_q register.

Test Plan:
- ADD 1+3 → 4, status 000. ADD 255+2 → 1, status[0]=1. ADD 255+1 → 0, status 001. ADD 0+0 → 0, status 100.
- SUB 63-15 → 48, status 000. SUB 14-15 → 255, status 010. SUB 126-126 → 0, status 100.
- AND CC&AA → 88. AND CC&33 → 00, status 100. OR F0|0F → FF. OR 00|00 → 00, status 100. XOR F0^F0 → 00, status 100.
- NOT with B=0F → F0. NOT with B=AC → 53. NOT with B=FF → 00, status 100; A is ignored in all cases.
- SHL 76 by 1 → EC. SHL 06 by 3 → 30. SHL F6 by 0x33 → 00, status 100. SHR 80 by 7 → 01. VAL param=5A → 5A.
- flags_q:
  - Assert rst_n low → flags_q=000 without a clock edge.
  - Clock ADD 255+1 → flags_q=001.
  - Clock NOP → flags_q holds 001.
  - Clock SUB 14-15 → flags_q=010.

Source files
------------

// File: rtl/alu_j_pkg.sv
// alu_j_pkg: shared constants for the Jac1-8 ALU.
//   - Datapath widths (data, opcode, immediate/shift count, status).
//   - Opcode encodings. ROL/ROR are only decoded when ALU_J_ROTATE_EN is defined.
//   - Bit positions inside the status vector.
package alu_j_pkg;

   localparam int DATA_WIDTH      = 8;
   localparam int NUM_OPCODE_BITS = 5;
   localparam int PARAM_BITS      = 8;
   localparam int NUM_STATUS_BITS = 3;

   localparam logic [NUM_OPCODE_BITS-1:0] OP_NOP = 5'b00000;
   localparam logic [NUM_OPCODE_BITS-1:0] OP_ADD = 5'b00001;
   localparam logic [NUM_OPCODE_BITS-1:0] OP_SUB = 5'b00010;
   localparam logic [NUM_OPCODE_BITS-1:0] OP_AND = 5'b00011;
   localparam logic [NUM_OPCODE_BITS-1:0] OP_OR  = 5'b00100;
   localparam logic [NUM_OPCODE_BITS-1:0] OP_NOT = 5'b00101;
   localparam logic [NUM_OPCODE_BITS-1:0] OP_XOR = 5'b00110;
   localparam logic [NUM_OPCODE_BITS-1:0] OP_SHL = 5'b00111;
   localparam logic [NUM_OPCODE_BITS-1:0] OP_SHR = 5'b01000;
   localparam logic [NUM_OPCODE_BITS-1:0] OP_VAL = 5'b01001;
   localparam logic [NUM_OPCODE_BITS-1:0] OP_ROL = 5'b01010;
   localparam logic [NUM_OPCODE_BITS-1:0] OP_ROR = 5'b01011;

   localparam int STAT_CARRY  = 0;
   localparam int STAT_BORROW = 1;
   localparam int STAT_ZERO   = 2;

endpackage

// File: rtl/alu_j_shifter.sv
// alu_j_shifter: combinational shift unit of the Jac1-8 ALU.
//   opcode  in  operation select; only SHL/SHR (and ROL/ROR) produce output
//   operand in  value to shift (operand A)
//   param   in  shift count; the full width counts for SHL/SHR, low bits for rotates
//   result  out shifted value, zero for any other opcode
// Optional: ALU_J_ROTATE_EN adds rotate-left/right by param[2:0].
module alu_j_shifter
   import alu_j_pkg::*;
(
   input  logic [NUM_OPCODE_BITS-1:0] opcode,
   input  logic [DATA_WIDTH-1:0]      operand,
   input  logic [PARAM_BITS-1:0]      param,
   output logic [DATA_WIDTH-1:0]      result
);

   localparam int SHAMT_BITS = $clog2(DATA_WIDTH);

   logic                  in_range;
   logic [SHAMT_BITS-1:0] shamt;
   logic [DATA_WIDTH-1:0] shl_result;
   logic [DATA_WIDTH-1:0] shr_result;

   // Counts of DATA_WIDTH or more shift every bit out, so only the low bits
   // need a real barrel shifter; the rest just force zero.
   assign in_range   = (param < PARAM_BITS'(DATA_WIDTH));
   assign shamt      = param[SHAMT_BITS-1:0];
   assign shl_result = in_range ? (operand << shamt) : '0;
   assign shr_result = in_range ? (operand >> shamt) : '0;

`ifdef ALU_J_ROTATE_EN
   logic [DATA_WIDTH-1:0] rol_result;
   logic [DATA_WIDTH-1:0] ror_result;

   // Index arithmetic in SHAMT_BITS wraps modulo DATA_WIDTH, which is exactly
   // the rotate.
   for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_rot
      assign rol_result[gi] = operand[SHAMT_BITS'(gi) - shamt];
      assign ror_result[gi] = operand[SHAMT_BITS'(gi) + shamt];
   end
`endif

   always_comb begin
      result = '0;
      case (opcode)
         OP_SHL:  result = shl_result;
         OP_SHR:  result = shr_result;
`ifdef ALU_J_ROTATE_EN
         OP_ROL:  result = rol_result;
         OP_ROR:  result = ror_result;
`endif
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu_j.sv
// alu_j: 8-bit integer ALU for the Jac1-8 CPU datapath.
//   clk      in  system clock, rising edge
//   rst_n    in  asynchronous active-low reset (clears flags_q only)
//   opcode   in  operation select
//   operand1 in  operand A
//   operand2 in  operand B
//   param    in  immediate value / shift count
//   result   out combinational result
//   status   out combinational flags {zero, borrow, carry}
//   flags_q  out status of the last non-NOP operation, registered
// Optional: ALU_J_ROTATE_EN enables ROL/ROR; otherwise those opcodes act as NOP.
module alu_j
   import alu_j_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_OPCODE_BITS-1:0] opcode,
   input  logic [DATA_WIDTH-1:0]      operand1,
   input  logic [DATA_WIDTH-1:0]      operand2,
   input  logic [PARAM_BITS-1:0]      param,
   output logic [DATA_WIDTH-1:0]      result,
   output logic [NUM_STATUS_BITS-1:0] status,
   output logic [NUM_STATUS_BITS-1:0] flags_q
);

   logic [DATA_WIDTH:0]          sum_ext;
   logic [DATA_WIDTH:0]          diff_ext;
   logic [DATA_WIDTH-1:0]        shift_result;
   logic [DATA_WIDTH-1:0]        alu_result;
   logic                         carry;
   logic                         borrow;
   logic                         valid_op;
   logic [NUM_STATUS_BITS-1:0]   status_next;
   logic [NUM_STATUS_BITS-1:0]   flags_reg;

   // One extra bit holds the carry out / borrow; for the difference it is set
   // exactly when operand1 < operand2 unsigned.
   assign sum_ext  = {1'b0, operand1} + {1'b0, operand2};
   assign diff_ext = {1'b0, operand1} - {1'b0, operand2};

   alu_j_shifter u_shifter (
      .opcode  (opcode),
      .operand (operand1),
      .param   (param),
      .result  (shift_result)
   );

   always_comb begin
      alu_result = '0;
      carry      = 1'b0;
      borrow     = 1'b0;
      valid_op   = 1'b1;
      case (opcode)
         OP_ADD: begin
            alu_result = sum_ext[DATA_WIDTH-1:0];
            carry      = sum_ext[DATA_WIDTH];
         end
         OP_SUB: begin
            alu_result = diff_ext[DATA_WIDTH-1:0];
            borrow     = diff_ext[DATA_WIDTH];
         end
         OP_AND:  alu_result = operand1 & operand2;
         OP_OR:   alu_result = operand1 | operand2;
         OP_NOT:  alu_result = ~operand2;
         OP_XOR:  alu_result = operand1 ^ operand2;
         OP_SHL,
         OP_SHR:  alu_result = shift_result;
         OP_VAL:  alu_result = param;
`ifdef ALU_J_ROTATE_EN
         OP_ROL,
         OP_ROR:  alu_result = shift_result;
`endif
         default: valid_op = 1'b0;
      endcase
   end

   // NOP yields result 0 but must not raise the zero flag, hence valid_op.
   // A carry-out with a zero result (255+1) is also not reported as zero.
   always_comb begin
      status_next              = '0;
      status_next[STAT_CARRY]  = carry;
      status_next[STAT_BORROW] = borrow;
      status_next[STAT_ZERO]   = valid_op && (alu_result == '0) && !carry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_reg <= '0;
      end else if (valid_op) begin
         flags_reg <= status_next;
      end
   end

   assign result  = alu_result;
   assign status  = status_next;
   assign flags_q = flags_reg;

endmodule

// File: tb/tb_alu_j.sv
// tb_alu_j: scoreboard bench for alu_j. Stimulus drives one vector per cycle
// just after the rising edge and queues the hand-computed response; the
// monitor pops and compares on each falling edge.
module tb_alu_j;
   import alu_j_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [4:0] opcode;
   logic [7:0] operand1;
   logic [7:0] operand2;
   logic [7:0] param;
   logic [7:0] result;
   logic [2:0] status;
   logic [2:0] flags_q;

   typedef struct {
      string      name;
      logic [7:0] res;
      logic [2:0] stat;
      bit         chk_flags;
      logic [2:0] flags;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   alu_j dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .opcode   (opcode),
      .operand1 (operand1),
      .operand2 (operand2),
      .param    (param),
      .result   (result),
      .status   (status),
      .flags_q  (flags_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: the design answers combinationally, so the response for the
   // vector driven after the last rising edge is present at this falling edge.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         checks++;
         if (result !== e.res) begin
            errors++;
            $display("FAIL %s result: got %02h expected %02h", e.name, result, e.res);
         end
         checks++;
         if (status !== e.stat) begin
            errors++;
            $display("FAIL %s status: got %03b expected %03b", e.name, status, e.stat);
         end
         if (e.chk_flags) begin
            checks++;
            if (flags_q !== e.flags) begin
               errors++;
               $display("FAIL %s flags_q: got %03b expected %03b", e.name, flags_q, e.flags);
            end
         end
         $display("txn %-14s op=%05b a=%02h b=%02h p=%02h -> result=%02h status=%03b flags_q=%03b",
                  e.name, opcode, operand1, operand2, param, result, status, flags_q);
      end
   end

   task automatic issue(input string name, input logic [4:0] op,
                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] p,
                        input logic [7:0] eres, input logic [2:0] estat,
                        input bit chk, input logic [2:0] eflags);
      exp_t e;
      @(posedge clk);
      #1;
      opcode   = op;
      operand1 = a;
      operand2 = b;
      param    = p;
      e.name      = name;
      e.res       = eres;
      e.stat      = estat;
      e.chk_flags = chk;
      e.flags     = eflags;
      sb_q.push_back(e);
   endtask

   initial begin
      rst_n    = 1'b0;
      opcode   = OP_NOP;
      operand1 = '0;
      operand2 = '0;
      param    = '0;

      // Reset state; result/status still work while reset is held.
      issue("reset_add",  OP_ADD, 8'h01, 8'h03, 8'h00, 8'h04, 3'b000, 1, 3'b000);
      rst_n = 1'b1;

      issue("add_1_3",    OP_ADD, 8'h01, 8'h03, 8'h00, 8'h04, 3'b000, 0, 3'b000);
      issue("add_ff_02",  OP_ADD, 8'hFF, 8'h02, 8'h00, 8'h01, 3'b001, 0, 3'b000);
      issue("add_ff_01",  OP_ADD, 8'hFF, 8'h01, 8'h00, 8'h00, 3'b001, 0, 3'b000);
      issue("add_0_0",    OP_ADD, 8'h00, 8'h00, 8'h00, 8'h00, 3'b100, 0, 3'b000);
      issue("sub_63_15",  OP_SUB, 8'h3F, 8'h0F, 8'h00, 8'h30, 3'b000, 0, 3'b000);
      issue("sub_14_15",  OP_SUB, 8'h0E, 8'h0F, 8'h00, 8'hFF, 3'b010, 0, 3'b000);
      issue("sub_126",    OP_SUB, 8'h7E, 8'h7E, 8'h00, 8'h00, 3'b100, 0, 3'b000);
      issue("and_cc_aa",  OP_AND, 8'hCC, 8'hAA, 8'h00, 8'h88, 3'b000, 0, 3'b000);
      issue("and_cc_33",  OP_AND, 8'hCC, 8'h33, 8'h00, 8'h00, 3'b100, 0, 3'b000);
      issue("or_f0_0f",   OP_OR,  8'hF0, 8'h0F, 8'h00, 8'hFF, 3'b000, 0, 3'b000);
      issue("or_00_00",   OP_OR,  8'h00, 8'h00, 8'h00, 8'h00, 3'b100, 0, 3'b000);
      issue("xor_f0_f0",  OP_XOR, 8'hF0, 8'hF0, 8'h00, 8'h00, 3'b100, 0, 3'b000);
      issue("xor_5a_ff",  OP_XOR, 8'h5A, 8'hFF, 8'h00, 8'hA5, 3'b000, 0, 3'b000);
      issue("not_0f",     OP_NOT, 8'hFF, 8'h0F, 8'h00, 8'hF0, 3'b000, 0, 3'b000);
      issue("not_ac",     OP_NOT, 8'h00, 8'hAC, 8'h00, 8'h53, 3'b000, 0, 3'b000);
      issue("not_ff",     OP_NOT, 8'h12, 8'hFF, 8'h00, 8'h00, 3'b100, 0, 3'b000);
      issue("shl_76_1",   OP_SHL, 8'h76, 8'h00, 8'h01, 8'hEC, 3'b000, 0, 3'b000);
      issue("shl_06_3",   OP_SHL, 8'h06, 8'h00, 8'h03, 8'h30, 3'b000, 0, 3'b000);
      issue("shl_f6_33",  OP_SHL, 8'hF6, 8'h00, 8'h33, 8'h00, 3'b100, 0, 3'b000);
      issue("shl_81_7",   OP_SHL, 8'h81, 8'h00, 8'h07, 8'h80, 3'b000, 0, 3'b000);
      issue("shl_81_8",   OP_SHL, 8'h81, 8'h00, 8'h08, 8'h00, 3'b100, 0, 3'b000);
      issue("shr_80_7",   OP_SHR, 8'h80, 8'h00, 8'h07, 8'h01, 3'b000, 0, 3'b000);
      issue("shr_f0_4",   OP_SHR, 8'hF0, 8'h00, 8'h04, 8'h0F, 3'b000, 0, 3'b000);
      issue("shr_01_1",   OP_SHR, 8'h01, 8'h00, 8'h01, 8'h00, 3'b100, 0, 3'b000);
      issue("shr_ff_8",   OP_SHR, 8'hFF, 8'h00, 8'h08, 8'h00, 3'b100, 0, 3'b000);
      issue("val_5a",     OP_VAL, 8'h00, 8'h00, 8'h5A, 8'h5A, 3'b000, 0, 3'b000);
      issue("val_00",     OP_VAL, 8'hFF, 8'hFF, 8'h00, 8'h00, 3'b100, 0, 3'b000);
      issue("nop",        OP_NOP, 8'hFF, 8'hFF, 8'hFF, 8'h00, 3'b000, 0, 3'b000);
      issue("undef_1f",   5'b11111, 8'hFF, 8'h01, 8'h00, 8'h00, 3'b000, 0, 3'b000);
      issue("undef_0c",   5'b01100, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 0, 3'b000);
`ifdef ALU_J_ROTATE_EN
      issue("rol_81_1",   OP_ROL, 8'h81, 8'h00, 8'h01, 8'h03, 3'b000, 0, 3'b000);
      issue("rol_81_9",   OP_ROL, 8'h81, 8'h00, 8'h09, 8'h03, 3'b000, 0, 3'b000);
      issue("ror_81_1",   OP_ROR, 8'h81, 8'h00, 8'h01, 8'hC0, 3'b000, 0, 3'b000);
      issue("ror_00_3",   OP_ROR, 8'h00, 8'h00, 8'h03, 8'h00, 3'b100, 0, 3'b000);
`else
      issue("rol_as_nop", OP_ROL, 8'h81, 8'h00, 8'h01, 8'h00, 3'b000, 0, 3'b000);
      issue("ror_as_nop", OP_ROR, 8'h81, 8'h00, 8'h01, 8'h00, 3'b000, 0, 3'b000);
`endif

      // flags_q sequence: the value seen in a cycle reflects earlier cycles.
      issue("fl_add_ff_01", OP_ADD, 8'hFF, 8'h01, 8'h00, 8'h00, 3'b001, 0, 3'b000);
      issue("fl_nop_a",     OP_NOP, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 1, 3'b001);
      issue("fl_nop_b",     OP_NOP, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 1, 3'b001);
      issue("fl_sub_14_15", OP_SUB, 8'h0E, 8'h0F, 8'h00, 8'hFF, 3'b010, 1, 3'b001);
      issue("fl_nop_c",     OP_NOP, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 1, 3'b010);
      // Reset dropped between edges: flags_q must clear before any rising edge.
      issue("fl_async_rst", OP_ADD, 8'h01, 8'h03, 8'h00, 8'h04, 3'b000, 1, 3'b000);
      rst_n = 1'b0;
      issue("fl_rst_hold",  OP_NOP, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 1, 3'b000);
      rst_n = 1'b1;
      issue("fl_post_rst",  OP_NOP, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 1, 3'b000);

      for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
      if (sb_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d responses outstanding, expected 0", sb_q.size());
      end
      @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
